// File: rtl/clk_branch_seq.sv
// Staggered enable sequencer for clock-tree branches.
// Branch clock-gate enables are turned on one at a time, in order 0..NBR-1,
// and turned off in reverse order. Successive enable changes are at least
// STEP cycles apart, which limits supply di/dt. The requester uses a 4-phase
// REQ/ACK handshake, and ACK means every unmasked branch is on. The block
// lives in the always-on domain and is clocked by the ungated root clock.
module clk_branch_seq #(
    parameter int NBR  = 4,
    parameter int STEP = 8
) (
    input  logic           CLK,
    input  logic           RN,
    input  logic           REQ,
    input  logic [NBR-1:0] MASK,
    output logic [NBR-1:0] EN,
    output logic           ACK,
    output logic           BUSY
);

    // Step counter width is derived from STEP and cannot be set by the user.
    localparam int CW = (STEP > 1) ? $clog2(STEP) : 1;
    // The level register must be able to hold the values 0..NBR.
    localparam int LW = $clog2(NBR + 1);

    localparam logic [CW-1:0] CNT_MAX = CW'(STEP - 1);
    localparam logic [LW-1:0] LVL_MAX = LW'(NBR);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_UP   = 2'd1,
        S_ON   = 2'd2,
        S_DOWN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   lvl_q, lvl_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ack_q, ack_d;
    logic [NBR-1:0]  en_q;
    logic            busy_q;

    // Thermometer code: bit i is set when i is below level l.
    function automatic logic [NBR-1:0] therm(input logic [LW-1:0] l);
        logic [NBR-1:0] t;
        t = '0;
        for (int i = 0; i < NBR; i++) begin
            t[i] = (i < int'(l));
        end
        return t;
    endfunction

    // Next-state decode. REQ is only looked at while OFF or ON, or at a step
    // boundary (cnt_q == 0). A REQ pulse between boundaries is therefore ignored.
    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        ack_d   = ack_q;
        case (state_q)
            S_OFF: begin
                if (REQ) begin
                    state_d = S_UP;
                    lvl_d   = LW'(1);
                    cnt_d   = CNT_MAX;
                end else begin
                    state_d = S_OFF;
                end
            end
            S_ON: begin
                if (!REQ) begin
                    state_d = S_DOWN;
                    lvl_d   = LVL_MAX - LW'(1);
                    cnt_d   = CNT_MAX;
                end else begin
                    state_d = S_ON;
                end
            end
            S_UP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!REQ) begin
                    state_d = S_DOWN;
                    lvl_d   = lvl_q - LW'(1);
                    cnt_d   = CNT_MAX;
                end else if (lvl_q == LVL_MAX) begin
                    state_d = S_ON;
                    ack_d   = 1'b1;
                end else begin
                    lvl_d = lvl_q + LW'(1);
                    cnt_d = CNT_MAX;
                end
            end
            S_DOWN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (REQ) begin
                    // A reversal keeps ACK unchanged; it is cleared only on reaching OFF.
                    state_d = S_UP;
                    lvl_d   = lvl_q + LW'(1);
                    cnt_d   = CNT_MAX;
                end else if (lvl_q == '0) begin
                    state_d = S_OFF;
                    ack_d   = 1'b0;
                end else begin
                    lvl_d = lvl_q - LW'(1);
                    cnt_d = CNT_MAX;
                end
            end
            default: begin
                state_d = S_OFF;
                lvl_d   = '0;
                cnt_d   = '0;
                ack_d   = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs. EN follows the next level every
    // cycle, so a MASK change shows up on EN at the following edge.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= S_OFF;
            lvl_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            en_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            en_q    <= therm(lvl_d) & ~MASK;
            busy_q  <= (state_d == S_UP) || (state_d == S_DOWN);
        end
    end

    assign EN   = en_q;
    assign ACK  = ack_q;
    assign BUSY = busy_q;

endmodule
